// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants, ratio type and clamp helper for the clock divider
package clk_div_pkg;

    localparam int unsigned MIN_DIV   = 2;
    localparam int unsigned DIV_W_MAX = 32;

    // Widest ratio any channel may use; channels narrow it to their own DIV_WIDTH.
    typedef logic [DIV_W_MAX-1:0] div_t;

    function automatic div_t clamp_div(input div_t n);
        return (n < div_t'(MIN_DIV)) ? div_t'(MIN_DIV) : n;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// rtl/clk_div_channel.sv - one divider channel with shadowed ratio applied at period boundaries
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 wr_en,
    input  logic [DIV_WIDTH-1:0] wr_div,
    input  logic                 resync,
    output logic                 clk_out,
    output logic                 tick,
    output logic                 pending
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] active_q, active_d;
    logic [DIV_WIDTH-1:0] shadow_q, shadow_d;
    logic                 clk_out_q, clk_out_d;
    logic                 tick_q, tick_d;
    logic                 pending_q, pending_d;
    logic [DIV_WIDTH-1:0] cnt_inc;
    logic [DIV_WIDTH-1:0] wr_clamped;

    assign wr_clamped = DIV_WIDTH'(clamp_div(div_t'(wr_div)));
    assign cnt_inc    = (cnt_q == active_q - DIV_WIDTH'(1)) ? '0 : cnt_q + DIV_WIDTH'(1);

    always_comb begin
        cnt_d     = cnt_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        clk_out_d = clk_out_q;
        tick_d    = tick_q;
        pending_d = pending_q;

        if (!en) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
            tick_d    = 1'b0;
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (resync) begin
            cnt_d     = '0;
            clk_out_d = 1'b1;
            tick_d    = 1'b1;
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else begin
            cnt_d     = cnt_inc;
            clk_out_d = (cnt_inc < (active_q >> 1));
            tick_d    = (cnt_inc == '0);
            if (cnt_inc == '0) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end

        // A write lands after any apply on this edge, so it is judged against the new ratio.
        if (wr_en) begin
            shadow_d  = wr_clamped;
            pending_d = (wr_clamped != active_d);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            active_q  <= DIV_WIDTH'(DEFAULT_DIV);
            shadow_q  <= DIV_WIDTH'(DEFAULT_DIV);
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign pending = pending_q;

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - NUM_CH runtime-programmable clock dividers with global resync
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic                      wr_en,
    input  logic [$clog2(NUM_CH)-1:0] wr_ch,
    input  logic [DIV_WIDTH-1:0]      wr_div,
    input  logic                      resync,
    output logic [NUM_CH-1:0]         clk_out,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH-1:0]         pending
);

    logic [NUM_CH-1:0] wr_sel;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range channel numbers match no index and the write is dropped.
        assign wr_sel[i] = wr_en && (int'(wr_ch) == i);

        clk_div_channel #(
            .DIV_WIDTH   (DIV_WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_in  (clk_in),
            .rst_n   (rst_n),
            .en      (ch_en[i]),
            .wr_en   (wr_sel[i]),
            .wr_div  (wr_div),
            .resync  (resync),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

endmodule
